// File: rtl/game_sequencer.sv
// Game-flow controller: frame tick prescaler plus the serve/play/miss/over/win
// phase machine that issues one-cycle restart, respawn and life commands.
module game_sequencer #(
  parameter int TICK_DIV  = 416667,
  parameter int TICK_W    = 19,
  parameter int MISS_HOLD = 60,
  parameter int HOLD_W    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_launch,
  input  logic       i_ball_lost,
  input  logic [1:0] i_life,
  input  logic [3:0] i_brick,
  output logic       o_tick,
  output logic       o_run,
  output logic       o_new_game,
  output logic       o_respawn,
  output logic       o_life_dec,
  output logic [2:0] o_state,
  output logic       o_over,
  output logic       o_win
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(MISS_HOLD);

  state_t            state;
  logic [TICK_W-1:0] cnt;
  logic [HOLD_W-1:0] hold;

  assign o_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hold       <= '0;
      o_tick     <= 1'b0;
      o_run      <= 1'b0;
      o_new_game <= 1'b0;
      o_respawn  <= 1'b0;
      o_life_dec <= 1'b0;
      o_over     <= 1'b0;
      o_win      <= 1'b0;
    end else begin
      // Frame prescaler runs regardless of game phase
      o_tick <= (cnt == TICK_LAST);
      cnt    <= (cnt == TICK_LAST) ? '0 : cnt + 1'b1;

      o_new_game <= 1'b0;
      o_respawn  <= 1'b0;
      o_life_dec <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_SERVE;
            o_new_game <= 1'b1;
            o_respawn  <= 1'b1;
          end
        end
        S_SERVE: begin
          if (i_launch) begin
            state <= S_PLAY;
            o_run <= 1'b1;
          end
        end
        S_PLAY: begin
          // Clearing the last brick wins even if the ball drops in the same cycle
          if (i_brick == 4'd0) begin
            state <= S_WIN;
            o_run <= 1'b0;
            o_win <= 1'b1;
          end else if (i_ball_lost) begin
            state      <= S_MISS;
            o_run      <= 1'b0;
            hold       <= '0;
            o_life_dec <= (i_life != 2'd0);
          end
        end
        S_MISS: begin
          // i_life already reflects the decrement issued on entry
          if (hold == HOLD_END) begin
            if (i_life == 2'd0) begin
              state  <= S_OVER;
              o_over <= 1'b1;
            end else begin
              state     <= S_SERVE;
              o_respawn <= 1'b1;
            end
          end else if (o_tick) begin
            hold <= hold + 1'b1;
          end
        end
        S_OVER, S_WIN: begin
          if (i_start) begin
            state      <= S_SERVE;
            o_new_game <= 1'b1;
            o_respawn  <= 1'b1;
            o_over     <= 1'b0;
            o_win      <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_run  <= 1'b0;
          o_over <= 1'b0;
          o_win  <= 1'b0;
        end
      endcase
    end
  end

endmodule
